// File: rtl/nn_pkg.sv
// Shared widths helpers and FSM encodings for the conv output serializer slice.
package nn_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned chan_w(input int unsigned output_channel);
    return clog2_min1(output_channel);
  endfunction

  function automatic int unsigned pix_w(input int unsigned input_size);
    return clog2_min1(input_size * input_size);
  endfunction

endpackage

// File: rtl/pconv_out_serializer_if.sv
// Parallel-vector input and serialized channel stream of the conv output serializer.
interface pconv_out_serializer_if
  import nn_pkg::*;
#(
  parameter int unsigned N              = 16,
  parameter int unsigned OUTPUT_CHANNEL = 32
) ();

  localparam int unsigned CHAN_W = chan_w(OUTPUT_CHANNEL);

  logic [OUTPUT_CHANNEL*N-1:0] conv_dout;
  logic                        conv_dout_vld;
  logic [N-1:0]                m_data;
  logic [CHAN_W-1:0]           m_chan;
  logic                        m_vld;
  logic                        m_ready;
  logic                        m_last;

  modport master (
    input  conv_dout, conv_dout_vld, m_ready,
    output m_data, m_chan, m_vld, m_last
  );

  modport slave (
    output conv_dout, conv_dout_vld, m_ready,
    input  m_data, m_chan, m_vld, m_last
  );

endinterface

// File: rtl/nn_vec_fifo.sv
// Vector FIFO with registered full/empty flags and a synchronous clear.
module nn_vec_fifo #(
  parameter int unsigned W     = 512,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty_q && !clr;
  assign do_push = push && !clr && ((count_q != FULL_CNT) || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (clr) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

  assign dout  = mem[rd_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/pconv_out_serializer.sv
// Buffers parallel conv output vectors and emits them one channel per
// accepted beat, tracking the pixel position within a frame.
module pconv_out_serializer
  import nn_pkg::*;
#(
  parameter int unsigned N              = 16,
  parameter int unsigned OUTPUT_CHANNEL = 32,
  parameter int unsigned INPUT_SIZE     = 6,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  pconv_out_serializer_if.master   bus,
  output logic                     fifo_full,
  output logic                     overflow,
  output logic                     frame_done
);

  localparam int unsigned VW     = OUTPUT_CHANNEL * N;
  localparam int unsigned CHAN_W = chan_w(OUTPUT_CHANNEL);
  localparam int unsigned PIX_W  = pix_w(INPUT_SIZE);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CHAN_W-1:0] CHAN_LAST   = CHAN_W'(OUTPUT_CHANNEL - 1);
  localparam logic [CHAN_W-1:0] CHAN_PENULT = CHAN_W'(OUTPUT_CHANNEL - 2);
  localparam logic [PIX_W-1:0]  PIX_LAST    = PIX_W'(INPUT_SIZE * INPUT_SIZE - 1);
  localparam logic [CNT_W-1:0]  FIFO_CAP    = CNT_W'(FIFO_DEPTH);

  ser_state_e        state_q;
  logic [VW-1:0]     vec_q;
  logic [N-1:0]      m_data_q;
  logic [CHAN_W-1:0] chan_q;
  logic [PIX_W-1:0]  pix_q;
  logic              m_vld_q, m_last_q, frame_done_q, overflow_q;

  logic [VW-1:0]     head;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              flush_c, xfer_c, chan_last_c, pop_c, push_c, drop_c;
  logic [PIX_W-1:0]  pix_nxt_c;

  assign flush_c     = !ce;
  assign xfer_c      = m_vld_q && bus.m_ready;
  assign chan_last_c = (chan_q == CHAN_LAST);
  assign pix_nxt_c   = (pix_q == PIX_LAST) ? '0 : pix_q + 1'b1;

  // Pop on an idle load or back-to-back after the final channel is taken.
  assign pop_c  = ce && !fifo_empty &&
                  ((state_q == ST_IDLE) || (xfer_c && chan_last_c));
  assign push_c = ce && bus.conv_dout_vld && ((fifo_count < FIFO_CAP) || pop_c);
  assign drop_c = ce && bus.conv_dout_vld && !push_c;

  nn_vec_fifo #(
    .W     (VW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush_c),
    .push  (push_c),
    .pop   (pop_c),
    .din   (bus.conv_dout),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // vec_q holds the not-yet-presented channels; m_data_q is the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      m_data_q     <= '0;
      chan_q       <= '0;
      pix_q        <= '0;
      m_vld_q      <= 1'b0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (flush_c) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      m_data_q     <= '0;
      chan_q       <= '0;
      pix_q        <= '0;
      m_vld_q      <= 1'b0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= xfer_c && m_last_q;
      if (drop_c) overflow_q <= 1'b1;
      if (xfer_c && chan_last_c) pix_q <= pix_nxt_c;

      if (pop_c) begin
        state_q  <= ST_SHIFT;
        vec_q    <= head >> N;
        m_data_q <= head[N-1:0];
        chan_q   <= '0;
        m_vld_q  <= 1'b1;
        m_last_q <= 1'b0;
      end else if (xfer_c) begin
        if (!chan_last_c) begin
          vec_q    <= vec_q >> N;
          m_data_q <= vec_q[N-1:0];
          chan_q   <= chan_q + 1'b1;
          m_last_q <= (chan_q == CHAN_PENULT) && (pix_q == PIX_LAST);
        end else begin
          state_q  <= ST_IDLE;
          chan_q   <= '0;
          m_vld_q  <= 1'b0;
          m_last_q <= 1'b0;
        end
      end
    end
  end

  assign bus.m_data  = m_data_q;
  assign bus.m_chan  = chan_q;
  assign bus.m_vld   = m_vld_q;
  assign bus.m_last  = m_last_q;
  assign overflow    = overflow_q;
  assign frame_done  = frame_done_q;

endmodule

// File: doc/pconv_out_serializer.md
PCONV_OUT_SERIALIZER -- requirements
Module: pconv_out_serializer

Interface
REQ-001 The module SHALL have parameter N, default 16, data bit width per channel.
REQ-002 The module SHALL have parameter OUTPUT_CHANNEL, default 32, channels per parallel output vector.
REQ-003 The module SHALL have parameter INPUT_SIZE, default 6, feature-map side; one frame is INPUT_SIZE*INPUT_SIZE vectors.
REQ-004 The module SHALL have parameter FIFO_DEPTH, default 4, vector FIFO entries (power of two, >=2).
REQ-005 The module SHALL have port clk, input, 1 bit, the single clock; all state on rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit, reset, asynchronous, active-high.
REQ-007 The module SHALL have port ce, input, 1 bit, high-level enable.
REQ-008 The module SHALL have port conv_dout, input, OUTPUT_CHANNEL*N bits, parallel vector, channel i at bits [(i+1)*N-1:i*N].
REQ-009 The module SHALL have port conv_dout_vld, input, 1 bit, vector valid.
REQ-010 The module SHALL have port m_data, output, N bits, serialized channel value.
REQ-011 The module SHALL have port m_chan, output, $clog2(OUTPUT_CHANNEL) bits, channel index of m_data.
REQ-012 The module SHALL have port m_vld, output, 1 bit, m_data valid.
REQ-013 The module SHALL have port m_ready, input, 1 bit, downstream accept; transfer when m_vld&&m_ready.
REQ-014 The module SHALL have port m_last, output, 1 bit, high with the final channel of the final frame vector.
REQ-015 The module SHALL have port fifo_full, output, 1 bit, FIFO holds FIFO_DEPTH vectors.
REQ-016 The module SHALL have port overflow, output, 1 bit, sticky: a vector was dropped.
REQ-017 The module SHALL have port frame_done, output, 1 bit, one-cycle pulse after the m_last transfer.

Function
REQ-018 The module SHALL push conv_dout when ce && conv_dout_vld && (count<FIFO_DEPTH || pop this cycle).
REQ-019 The module SHALL drop a valid vector arriving while full with no simultaneous pop, and set overflow.
REQ-020 The serializer SHALL be a two-state FSM: IDLE (no vector loaded), SHIFT (vector loaded, emitting channels).
REQ-021 IDLE->SHIFT SHALL occur when the FIFO is non-empty and ce=1, popping the head into the output register and setting channel counter to 0.
REQ-022 In SHIFT, m_vld SHALL be 1, m_data = loaded channel m_chan, and it SHALL hold stable until m_ready.
REQ-023 On transfer with m_chan<OUTPUT_CHANNEL-1, the channel counter SHALL increment by one.
REQ-024 On transfer with m_chan=OUTPUT_CHANNEL-1, the pixel counter SHALL increment (wrapping to 0 at INPUT_SIZE*INPUT_SIZE-1), and the FSM SHALL pop the next vector back-to-back if available, else return to IDLE.
REQ-025 Latency: a vector pushed into an empty FIFO in cycle t SHALL yield m_vld=1 in cycle t+2, channel 0 first.
REQ-026 m_last SHALL equal m_vld && pixel counter = INPUT_SIZE*INPUT_SIZE-1 && m_chan = OUTPUT_CHANNEL-1.
REQ-027 frame_done SHALL pulse 1 cycle after the m_last transfer; the pixel counter is 0 in that same cycle.
REQ-028 Data SHALL pass unmodified; no arithmetic on channel values.
REQ-029 ce=0 SHALL synchronously flush: FIFO empty, counters 0, FSM IDLE, m_vld 0; overflow retained.

Reset
REQ-030 rst=1 SHALL asynchronously clear FIFO pointers, count, counters, FSM to IDLE, and drive m_vld, m_last, frame_done, fifo_full, overflow, m_data, m_chan to 0.
REQ-031 rst asserted mid-frame SHALL discard all buffered vectors; after release, the first push starts a new frame at pixel 0.

Structure
REQ-032 Shared package nn_pkg SHALL hold clog2-based width constants (channel/pixel counter widths) and FSM state encodings.
REQ-033 FIFO SHALL be sub-module nn_vec_fifo (width OUTPUT_CHANNEL*N, depth FIFO_DEPTH, push/pop/full/empty/count).

Verification
REQ-034 Single vector of channel values 0..31, m_ready=1 -> m_vld at t+2, m_chan 0..31 over 32 consecutive cycles, m_data=channel index.
REQ-035 36 vectors at 1 per 32 cycles, m_ready=1 -> 1152 transfers, m_last only on transfer 1152, frame_done one cycle later, overflow=0.
REQ-036 m_ready=0, 6 back-to-back vectors (FIFO_DEPTH=4) -> 1 in output register plus 4 buffered, fifo_full=1, 6th dropped, overflow=1 sticky.
REQ-037 m_ready toggled 1010.. -> m_data/m_chan stable while m_ready=0, no channel skipped or repeated.
REQ-038 rst at pixel 10 channel 5 -> all outputs 0 immediately; next frame's m_last lands on its 36th vector.
REQ-039 ce=0 for 1 cycle with 2 vectors buffered -> m_vld=0 next cycle, FIFO empty, overflow unchanged.
